// File: rtl/nand_page_reader.sv
`default_nettype none
// ============================================================================
//  Module   : nand_page_reader
//  Purpose  : Waits out tWB and R/B# busy, strobes RE# once per byte and
//             streams the captured IO bytes out over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module nand_page_reader #(
    parameter int unsigned PAGE_BYTES  = 2048,
    parameter int unsigned RE_LOW_CYC  = 2,
    parameter int unsigned RE_HIGH_CYC = 2,
    parameter int unsigned TWB_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic        RB,
    input  logic [7:0]  io_in,
    output logic        RE,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        done,
    output logic        timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TWB     = 3'd1;
    localparam logic [2:0] S_WAIT_RB = 3'd2;
    localparam logic [2:0] S_RE_LOW  = 3'd3;
    localparam logic [2:0] S_RE_HIGH = 3'd4;

    // One shared phase counter serves tWB, the R/B wait and both RE phases.
    localparam int unsigned MAX_A   = (TIMEOUT_CYC > TWB_CYC) ? TIMEOUT_CYC : TWB_CYC;
    localparam int unsigned MAX_B   = (RE_LOW_CYC > RE_HIGH_CYC) ? RE_LOW_CYC : RE_HIGH_CYC;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TWB_LAST  = CW'(TWB_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(RE_LOW_CYC - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(RE_HIGH_CYC - 1);
    localparam logic [15:0]   PAGE_LEN  = 16'(PAGE_BYTES);

    logic          rb_meta_q, rb_s_q;
    logic [2:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]   eff_len_q,  eff_len_d;
    logic          re_q,       re_d;
    logic          busy_q,     busy_d;
    logic [7:0]    dout_q,     dout_d;
    logic          valid_q,    valid_d;
    logic          done_q,     done_d;
    logic          timeout_q,  timeout_d;
    logic [15:0]   w_eff_len;

    assign w_eff_len = (len > PAGE_LEN) ? PAGE_LEN : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_meta_q <= 1'b0;
            rb_s_q    <= 1'b0;
        end else begin
            rb_meta_q <= RB;
            rb_s_q    <= rb_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        eff_len_d  = eff_len_q;
        re_d       = 1'b1;
        busy_d     = busy_q;
        dout_d     = dout_q;
        valid_d    = valid_q & ~data_ready;
        done_d     = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    eff_len_d  = w_eff_len;
                    byte_cnt_d = 16'd0;
                    cnt_d      = '0;
                    if (w_eff_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_TWB;
                    end
                end
            end
            S_TWB: begin
                if (cnt_q == TWB_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_RB: begin
                if (rb_s_q) begin
                    cnt_d   = '0;
                    re_d    = 1'b0;
                    state_d = S_RE_LOW;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RE_LOW: begin
                // The holding register is guaranteed free here: RE_LOW is only
                // entered when it was empty or being drained.
                if (cnt_q == LOW_LAST) begin
                    dout_d     = io_in;
                    valid_d    = 1'b1;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    cnt_d      = '0;
                    state_d    = S_RE_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    re_d  = 1'b0;
                end
            end
            S_RE_HIGH: begin
                if (cnt_q != HIGH_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (byte_cnt_q == eff_len_q) begin
                    if (valid_q && data_ready) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else if ((cnt_q == HIGH_LAST) && (!valid_q || data_ready)) begin
                    cnt_d   = '0;
                    re_d    = 1'b0;
                    state_d = S_RE_LOW;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= 16'd0;
            eff_len_q  <= 16'd0;
            re_q       <= 1'b1;
            busy_q     <= 1'b0;
            dout_q     <= 8'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            eff_len_q  <= eff_len_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign RE         = re_q;
    assign busy       = busy_q;
    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_page_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nand_page_reader
//  Purpose  : Self-checking bench; a flash model drives byte k after the k-th
//             RE fall and the expected stream/timing comes from the read rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nand_page_reader;

    localparam int PAGE = 8;
    localparam int RLO  = 2;
    localparam int RHI  = 2;
    localparam int TWB  = 4;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        RB;
    logic [7:0]  io_in;
    logic        RE;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        done;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nand_page_reader #(
        .PAGE_BYTES (PAGE),
        .RE_LOW_CYC (RLO),
        .RE_HIGH_CYC(RHI),
        .TWB_CYC    (TWB),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .RB        (RB),
        .io_in     (io_in),
        .RE        (RE),
        .busy      (busy),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .done      (done),
        .timeout   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generic read: rmode 0 = ready always high, 1 = random ready,
    // 2 = ready low for 10 cycles after the first byte appears.
    task automatic do_read(input string name, input int n_len, input int rb_at,
                           input bit glitch, input int rmode, input bit poke);
        int exp_n, t, t_first, falls, fall_t, rise_t, prev_fall_t;
        int got, last_acc_t, done_cnt, done_t, stall;
        logic [7:0] base, hold;
        bit holding, prev_re, prev_free, fin, rdy, seen_valid;
        exp_n   = (n_len > PAGE) ? PAGE : n_len;
        base    = 8'($urandom);
        t_first = (rb_at + 3 > TWB + 1) ? rb_at + 3 : TWB + 1;
        falls = 0; fall_t = 0; rise_t = 0; prev_fall_t = 0; got = 0;
        last_acc_t = -10; done_cnt = 0; done_t = 0; stall = 0;
        holding = 0; prev_re = 1; prev_free = 1; fin = 0; seen_valid = 0; hold = 8'd0;

        start = 1'b1; len = 16'(n_len); RB = 1'b0; data_ready = 1'b1;
        tick();
        start = 1'b0;
        len   = 16'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
        end
        t = 0;
        while (!fin) begin
            if (RE === 1'b0 && prev_re === 1'b1) begin
                falls++;
                checks++;
                if (falls == 1) begin
                    if (t != t_first) begin
                        failures++; $display("FAIL %s first_re_fall got=%0d exp=%0d", name, t, t_first);
                    end
                end else if (t - rise_t < RHI) begin
                    failures++; $display("FAIL %s re_high_width got=%0d exp>=%0d", name, t - rise_t, RHI);
                end
                if (falls > 1 && rmode == 0) begin
                    checks++;
                    if (t - prev_fall_t != RLO + RHI) begin
                        failures++; $display("FAIL %s byte_period got=%0d exp=%0d", name, t - prev_fall_t, RLO + RHI);
                    end
                end
                checks++;
                if (!prev_free) begin
                    failures++; $display("FAIL %s re_while_byte_pending got=1 exp=0", name);
                end
                prev_fall_t = t;
                fall_t      = t;
                io_in       = base + 8'(falls - 1);
            end
            if (RE === 1'b1 && prev_re === 1'b0) begin
                rise_t = t;
                checks++;
                if (t - fall_t != RLO) begin
                    failures++; $display("FAIL %s re_low_width got=%0d exp=%0d", name, t - fall_t, RLO);
                end
            end
            if (RE === 1'b0) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL %s busy_during_re got=%b exp=1", name, busy);
                end
            end
            if (holding) begin
                checks++;
                if (data_valid !== 1'b1 || data_out !== hold) begin
                    failures++; $display("FAIL %s stall_stability got=%b/%h exp=1/%h", name, data_valid, data_out, hold);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_t = t;
                checks++;
                if (t != last_acc_t + 1 || busy !== 1'b0 || got != exp_n) begin
                    failures++;
                    $display("FAIL %s done_pulse got=t%0d/busy%b/bytes%0d exp=t%0d/busy0/bytes%0d",
                             name, t, busy, got, last_acc_t + 1, exp_n);
                end
            end
            checks++;
            if (timeout !== 1'b0) begin
                failures++; $display("FAIL %s spurious_timeout got=%b exp=0", name, timeout);
            end

            // Next-cycle stimulus
            if (data_valid === 1'b1) seen_valid = 1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(seen_valid && stall < 10);
                    if (seen_valid && stall < 10) stall++;
                end
            endcase
            data_ready = rdy;
            if (data_valid === 1'b1 && rdy) begin
                checks++;
                if (got >= exp_n) begin
                    failures++; $display("FAIL %s extra_byte got=%0d exp=%0d", name, got + 1, exp_n);
                end else if (data_out !== base + 8'(got)) begin
                    failures++; $display("FAIL %s byte%0d got=%h exp=%h", name, got, data_out, base + 8'(got));
                end
                got++;
                last_acc_t = t;
                holding    = 0;
            end else if (data_valid === 1'b1) begin
                holding = 1;
                hold    = data_out;
            end else begin
                holding = 0;
            end
            prev_free = (data_valid !== 1'b1) || rdy;
            prev_re   = RE;
            start     = (poke && falls == 1 && rise_t == t && RE === 1'b1);
            if (start) len = 16'($urandom_range(1, 6));
            RB = glitch ? (t == 0 || t >= rb_at) : (t >= rb_at);

            if (done_cnt > 0 && t >= done_t + 4) fin = 1;
            if (t > 3000) begin
                failures++; $display("FAIL %s cycle_budget got=%0d exp<=3000", name, t);
                fin = 1;
            end
            tick();
            t++;
        end
        checks++;
        if (falls != exp_n || got != exp_n || done_cnt != 1) begin
            failures++;
            $display("FAIL %s totals got=re%0d/bytes%0d/done%0d exp=re%0d/bytes%0d/done1",
                     name, falls, got, done_cnt, exp_n, exp_n);
        end
        start = 1'b0; RB = 1'b0; data_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (RE !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'd0 ||
            done !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got=RE%b busy%b v%b d%h done%b to%b exp=RE1 busy0 v0 d00 done0 to0",
                     RE, busy, data_valid, data_out, done, timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_read("basic", 4, 20, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_read("backpressure", 3, 2, 1'b0, 2, 1'b0);
    endtask

    task automatic test_clamp();
        do_read("clamp", 20, 3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_len();
        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || RE !== 1'b1) begin
            failures++; $display("FAIL zero_len_done got=done%b busy%b RE%b exp=done1 busy0 RE1", done, busy, RE);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || RE !== 1'b1) begin
                failures++; $display("FAIL zero_len_after got=done%b busy%b RE%b exp=done0 busy0 RE1", done, busy, RE);
            end
        end
    endtask

    task automatic test_timeout();
        int tcnt;
        tcnt = 0;
        start = 1'b1; len = 16'd5; RB = 1'b0;
        tick();
        start = 1'b0;
        for (int t = 0; t < TWB + TMO + 10; t++) begin
            if (timeout === 1'b1) begin
                tcnt++;
                checks++;
                if (t != TWB + TMO || busy !== 1'b0) begin
                    failures++; $display("FAIL timeout_pulse got=t%0d/busy%b exp=t%0d/busy0", t, busy, TWB + TMO);
                end
            end
            if (t == TWB + TMO - 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL timeout_busy_before got=%b exp=1", busy);
                end
            end
            checks++;
            if (RE !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL timeout_quiet got=RE%b done%b exp=RE1 done0", RE, done);
            end
            tick();
        end
        checks++;
        if (tcnt != 1) begin
            failures++; $display("FAIL timeout_count got=%0d exp=1", tcnt);
        end
        do_read("after_timeout", 2, 1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_ignored_start_twb();
        do_read("ignored_start_twb", 5, 10, 1'b1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int t;
        data_ready = 1'b1; start = 1'b1; len = 16'd4; RB = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (RE !== 1'b0 && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (RE !== 1'b0) begin
            failures++; $display("FAIL reset_mid_reach_re_low got=%b exp=0", RE);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (RE !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                timeout !== 1'b0 || data_out !== 8'd0) begin
                failures++;
                $display("FAIL reset_mid got=RE%b v%b busy%b done%b to%b exp=RE1 v0 busy0 done0 to0",
                         RE, data_valid, busy, done, timeout);
            end
        end
        rst = 1'b0; RB = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (RE !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_after got=RE%b busy%b done%b to%b exp=RE1 busy0 done0 to0",
                         RE, busy, done, timeout);
            end
        end
    endtask

    task automatic test_random();
        int n, rb, md;
        bit gl, pk;
        for (int i = 0; i < 8; i++) begin
            n  = $urandom_range(1, 12);
            rb = $urandom_range(0, 12);
            md = $urandom_range(0, 2);
            gl = (rb >= 6) && ($urandom_range(0, 1) == 1);
            pk = ($urandom_range(0, 1) == 1);
            do_read("random", n, rb, gl, md, pk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = 16'd0; RB = 1'b0; io_in = 8'd0; data_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_clamp();
        test_zero_len();
        test_timeout();
        test_ignored_start_twb();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
